// File: rtl/seg_display_scan_pkg.sv
// seg_display_scan_pkg: shared codes, segment patterns and default timing for the scanned display
package seg_display_scan_pkg;
  localparam int SCAN_DIV_DEF = 50000;
  localparam int BLANK_CYC_DEF = 2500;
  localparam int BLINK_DIV_DEF = 25000000;
  localparam logic [3:0] CODE_A = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ALL = 7'b0000000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  // {g,f,e,d,c,b,a} active-low, indexed directly by the 4-bit code
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_OFF, SEG_A,
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit digit code to active-low seven-segment pattern
module seg7_decode
  import seg_display_scan_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  always_comb seg_o = SEG_TABLE[code_i];
endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: six-digit multiplexed display driver with per-frame snapshot, ghost blanking, blink and lamp test
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] d0_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d2_i,
  input  logic [3:0] d3_i,
  input  logic [3:0] d4_i,
  input  logic [3:0] d5_i,
  input  logic [5:0] blink_i,
  input  logic [5:0] dp_en_i,
  input  logic       lamp_test_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [5:0] an_o,
  output logic       frame_done_o
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [SW-1:0] slot_q, slot_d;
  logic [2:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic phase_q, phase_d, start_q, fd_q;
  logic [5:0][3:0] snap_q;
  logic [5:0] sblink_q, sdp_q, an_q, an_d;
  logic [6:0] seg_q, seg_d, dec;
  logic dp_q, dp_d, slot_end, bend, capture, ghost, blanked;
  seg7_decode u_dec (.code_i(snap_q[idx_q]), .seg_o(dec));
  // start_q holds the scan counters for the post-reset snapshot cycle so the first frame is full length
  always_comb begin
    slot_end = slot_q == SW'(SCAN_DIV - 1);
    bend = bcnt_q == BW'(BLINK_DIV - 1);
    capture = start_q | (slot_end & (idx_q == 3'd5));
    slot_d = start_q ? slot_q : slot_end ? '0 : slot_q + 1'b1;
    idx_d = (start_q | ~slot_end) ? idx_q : (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    bcnt_d = bend ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ bend;
    ghost = int'(slot_q) < BLANK_CYC;
    blanked = phase_q & sblink_q[idx_q];
    an_d = ghost ? 6'b111111 : ~(6'd1 << idx_q);
    seg_d = ghost ? SEG_OFF : lamp_test_i ? SEG_ALL : blanked ? SEG_OFF : dec;
    dp_d = ghost ? 1'b1 : lamp_test_i ? 1'b0 : ~(sdp_q[idx_q] & ~blanked);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
      start_q <= 1'b1;
      snap_q <= {6{CODE_BLANK}};
      sblink_q <= '0;
      sdp_q <= '0;
      an_q <= 6'b111111;
      seg_q <= SEG_OFF;
      dp_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
      start_q <= 1'b0;
      if (capture) begin
        snap_q <= {d5_i, d4_i, d3_i, d2_i, d1_i, d0_i};
        sblink_q <= blink_i;
        sdp_q <= dp_en_i;
      end
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fd_q <= capture;
    end
  end
  assign seg_o = seg_q;
  assign dp_o = dp_q;
  assign an_o = an_q;
  assign frame_done_o = fd_q;
endmodule
